// File: rtl/fu_lsu_pipe.sv
// Load/store functional unit: one EX slot computing vaddr = base + imm, a req/gnt memory
// port, and an in-order tracker of up to OUTSTANDING requests driving writeback/commit.
module fu_lsu_pipe #(
    parameter int unsigned OUTSTANDING   = 2,
    parameter int unsigned CHECK_ALIGN   = 1,
    parameter int unsigned INST_STATE_WD = 40,
    parameter int unsigned IMM_LSB       = 0,
    parameter int unsigned WE_BIT        = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [11:0]              op,
    input  logic [INST_STATE_WD-1:0] inst_status,
    input  logic [31:0]              rdata1,
    input  logic [31:0]              rdata2,
    output logic                     mem_req,
    input  logic                     mem_gnt,
    output logic [3:0]               mem_wen,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_rvalid,
    input  logic [31:0]              mem_rdata,
    output logic                     cb_we,
    output logic                     rf_we,
    output logic [31:0]              wdata,
    output logic [INST_STATE_WD-1:0] wb_status,
    output logic                     excp,
    output logic [31:0]              excp_badvaddr
);

    localparam int unsigned PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(OUTSTANDING + 1);
    localparam logic [CW-1:0] DEPTH = CW'(OUTSTANDING);
    localparam logic [PW-1:0] LAST  = PW'(OUTSTANDING - 1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // EX stage registers
    logic                     ex_valid;
    logic [7:0]               ex_op;
    logic [INST_STATE_WD-1:0] ex_status;
    logic [31:0]              ex_base;
    logic [31:0]              ex_data;

    // Tracker storage
    logic [INST_STATE_WD-1:0] trk_status [OUTSTANDING];
    logic [7:0]               trk_op     [OUTSTANDING];
    logic [3:0]               trk_sel    [OUTSTANDING];
    logic [31:0]              trk_vaddr  [OUTSTANDING];
    logic                     trk_exc    [OUTSTANDING];
    logic                     trk_killed [OUTSTANDING];
    logic [PW-1:0]            wr_ptr, rd_ptr;
    logic [CW-1:0]            count;

    logic        unused_op_hi;
    logic [31:0] vaddr;
    logic        is_byte, is_half, is_word, is_store;
    logic [3:0]  sel;
    logic        misaligned;
    logic [31:0] st_data;
    logic        not_full, push, pop, complete;
    logic        head_valid, head_exc;

    assign unused_op_hi = ^op[11:8];

    assign vaddr    = ex_base + ex_status[IMM_LSB +: 32];
    assign is_byte  = ex_op[7] | ex_op[6] | ex_op[2];
    assign is_half  = ex_op[5] | ex_op[4] | ex_op[1];
    assign is_word  = ex_op[3] | ex_op[0];
    assign is_store = |ex_op[2:0];

    always_comb begin
        sel = 4'b0000;
        if (is_byte)      sel = 4'b0001 << vaddr[1:0];
        else if (is_half) sel = vaddr[1] ? 4'b1100 : 4'b0011;
        else if (is_word) sel = 4'b1111;
    end

    assign misaligned = (CHECK_ALIGN != 0) &&
                        ((is_half && vaddr[0]) || (is_word && (vaddr[1:0] != 2'b00)));

    always_comb begin
        st_data = '0;
        if (ex_op[2])      st_data = {4{ex_data[7:0]}};
        else if (ex_op[1]) st_data = {2{ex_data[15:0]}};
        else if (ex_op[0]) st_data = ex_data;
    end

    // Misaligned ops bypass the port but still take a tracker slot so completions stay in order.
    assign not_full    = (count < DEPTH);
    assign mem_req     = ex_valid && !misaligned && not_full && !flush;
    assign push        = ex_valid && !flush && not_full && (misaligned || mem_gnt);
    assign issue_ready = !ex_valid || push;

    assign mem_addr  = ex_valid ? vaddr : '0;
    assign mem_wen   = (ex_valid && is_store) ? sel : 4'b0000;
    assign mem_wdata = ex_valid ? st_data : '0;

    assign head_valid = (count != '0);
    assign head_exc   = trk_exc[rd_ptr];
    assign pop        = head_valid && (head_exc || mem_rvalid);
    assign complete   = pop && !trk_killed[rd_ptr] && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_op     <= '0;
            ex_status <= '0;
            ex_base   <= '0;
            ex_data   <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (issue_valid && issue_ready) begin
            ex_valid  <= 1'b1;
            ex_op     <= op[7:0];
            ex_status <= inst_status;
            ex_base   <= rdata1;
            ex_data   <= rdata2;
        end else if (push) begin
            ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < OUTSTANDING; i++) begin
                trk_status[i] <= '0;
                trk_op[i]     <= '0;
                trk_sel[i]    <= '0;
                trk_vaddr[i]  <= '0;
                trk_exc[i]    <= 1'b0;
                trk_killed[i] <= 1'b0;
            end
        end else begin
            if (flush) begin
                for (int unsigned i = 0; i < OUTSTANDING; i++) trk_killed[i] <= 1'b1;
            end
            if (push) begin
                trk_status[wr_ptr] <= ex_status;
                trk_op[wr_ptr]     <= ex_op;
                trk_sel[wr_ptr]    <= sel;
                trk_vaddr[wr_ptr]  <= vaddr;
                trk_exc[wr_ptr]    <= misaligned;
                trk_killed[wr_ptr] <= 1'b0;
                wr_ptr             <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Load extension from the head entry's stored sel and op
    logic [7:0]               h_op;
    logic [3:0]               h_sel;
    logic [INST_STATE_WD-1:0] h_status;
    logic [7:0]               h_byte;
    logic [15:0]              h_half;
    logic [31:0]              ld_data;

    assign h_op     = trk_op[rd_ptr];
    assign h_sel    = trk_sel[rd_ptr];
    assign h_status = trk_status[rd_ptr];

    always_comb begin
        if (h_sel[3])      h_byte = mem_rdata[31:24];
        else if (h_sel[2]) h_byte = mem_rdata[23:16];
        else if (h_sel[1]) h_byte = mem_rdata[15:8];
        else               h_byte = mem_rdata[7:0];
        h_half = h_sel[2] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_data = '0;
        if (h_op[7])      ld_data = {{24{h_byte[7]}}, h_byte};
        else if (h_op[6]) ld_data = {24'b0, h_byte};
        else if (h_op[5]) ld_data = {{16{h_half[15]}}, h_half};
        else if (h_op[4]) ld_data = {16'b0, h_half};
        else if (h_op[3]) ld_data = mem_rdata;
    end

    assign cb_we         = complete;
    assign excp          = complete && head_exc;
    assign excp_badvaddr = (complete && head_exc) ? trk_vaddr[rd_ptr] : '0;
    assign rf_we         = complete && !head_exc && (|h_op[7:3]) && h_status[WE_BIT];
    assign wdata         = (complete && !head_exc) ? ld_data : '0;
    assign wb_status     = complete ? h_status : '0;

    a_rvalid_has_head: assert property (@(posedge clk) disable iff (rst)
        mem_rvalid |-> (head_valid && !head_exc));

endmodule

// File: tb/tb_fu_lsu_pipe.sv
// Directed self-checking bench for fu_lsu_pipe (OUTSTANDING=2, CHECK_ALIGN=1).
module tb_fu_lsu_pipe;

    localparam logic [11:0] OP_LB  = 12'h080;
    localparam logic [11:0] OP_LBU = 12'h040;
    localparam logic [11:0] OP_LH  = 12'h020;
    localparam logic [11:0] OP_LHU = 12'h010;
    localparam logic [11:0] OP_LW  = 12'h008;
    localparam logic [11:0] OP_SB  = 12'h004;
    localparam logic [11:0] OP_SH  = 12'h002;
    localparam logic [11:0] OP_SW  = 12'h001;

    logic        clk, rst, flush, issue_valid, issue_ready;
    logic [11:0] op;
    logic [39:0] inst_status, wb_status;
    logic [31:0] rdata1, rdata2, mem_addr, mem_wdata, mem_rdata, wdata, excp_badvaddr;
    logic        mem_req, mem_gnt, mem_rvalid, cb_we, rf_we, excp;
    logic [3:0]  mem_wen;

    int tests = 0;
    int fails = 0;

    fu_lsu_pipe #(
        .OUTSTANDING(2), .CHECK_ALIGN(1), .INST_STATE_WD(40), .IMM_LSB(0), .WE_BIT(32)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .op(op),
        .inst_status(inst_status), .rdata1(rdata1), .rdata2(rdata2),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .cb_we(cb_we), .rf_we(rf_we), .wdata(wdata), .wb_status(wb_status),
        .excp(excp), .excp_badvaddr(excp_badvaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [39:0] mk_st(input logic [31:0] imm, input logic we);
        return {7'b0, we, imm};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        flush = 0; issue_valid = 0; op = '0; inst_status = '0;
        rdata1 = '0; rdata2 = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic drive_issue(input logic [11:0] o, input logic [31:0] imm, input logic we,
                               input logic [31:0] base, input logic [31:0] data);
        issue_valid = 1; op = o; inst_status = mk_st(imm, we); rdata1 = base; rdata2 = data;
    endtask

    task automatic test_reset;
        rst = 1; idle_inputs();
        step();
        tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL reset_issue_ready: got %b want 1", issue_ready); end
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        tests++; if (cb_we !== 1'b0 || rf_we !== 1'b0 || excp !== 1'b0) begin fails++; $display("FAIL reset_wb: cb_we=%b rf_we=%b excp=%b want 0", cb_we, rf_we, excp); end
        tests++; if (mem_addr !== 32'h0 || mem_wen !== 4'h0 || wdata !== 32'h0) begin fails++; $display("FAIL reset_data: addr=%h wen=%h wdata=%h want 0", mem_addr, mem_wen, wdata); end
        rst = 0;
        step();
    endtask

    task automatic test_lw;
        drive_issue(OP_LW, 32'h4, 1'b1, 32'h100, 32'h0);
        #1;
        tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL lw_issue_ready: got %b want 1", issue_ready); end
        step();
        issue_valid = 0; mem_gnt = 1;
        #1;
        tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL lw_req: got %b want 1", mem_req); end
        tests++; if (mem_addr !== 32'h104) begin fails++; $display("FAIL lw_addr: got %h want 00000104", mem_addr); end
        tests++; if (mem_wen !== 4'b0000) begin fails++; $display("FAIL lw_wen: got %b want 0000", mem_wen); end
        step();
        mem_gnt = 0;
        #1;
        tests++; if (mem_req !== 1'b0 || cb_we !== 1'b0) begin fails++; $display("FAIL lw_wait: req=%b cb_we=%b want 0 0", mem_req, cb_we); end
        step();
        step();
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        #1;
        tests++; if (cb_we !== 1'b1 || rf_we !== 1'b1) begin fails++; $display("FAIL lw_wb: cb_we=%b rf_we=%b want 1 1", cb_we, rf_we); end
        tests++; if (wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_wdata: got %h want deadbeef", wdata); end
        tests++; if (excp !== 1'b0) begin fails++; $display("FAIL lw_excp: got %b want 0", excp); end
        tests++; if (wb_status !== mk_st(32'h4, 1'b1)) begin fails++; $display("FAIL lw_status: got %h want %h", wb_status, mk_st(32'h4, 1'b1)); end
        step();
        mem_rvalid = 0;
        #1;
        tests++; if (cb_we !== 1'b0) begin fails++; $display("FAIL lw_after: cb_we=%b want 0", cb_we); end
    endtask

    task automatic test_load_ext;
        logic [11:0] t_op   [6] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LB, OP_LBU};
        logic [31:0] t_imm  [6] = '{32'h3, 32'h3, 32'h2, 32'h0, 32'h1, 32'h0};
        logic [31:0] t_base [6] = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h300, 32'h300};
        logic [31:0] t_rd   [6] = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80FF1234, 32'h80FF1234, 32'h11228344, 32'h112283F4};
        logic [31:0] t_exp  [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00001234, 32'hFFFFFF83, 32'h000000F4};
        for (int i = 0; i < 6; i++) begin
            drive_issue(t_op[i], t_imm[i], 1'b1, t_base[i], 32'h0);
            step();
            issue_valid = 0; mem_gnt = 1;
            #1;
            tests++; if (mem_req !== 1'b1 || mem_addr !== t_base[i] + t_imm[i]) begin fails++; $display("FAIL ext_req[%0d]: req=%b addr=%h want 1 %h", i, mem_req, mem_addr, t_base[i] + t_imm[i]); end
            step();
            mem_gnt = 0; mem_rvalid = 1; mem_rdata = t_rd[i];
            #1;
            tests++; if (cb_we !== 1'b1 || rf_we !== 1'b1 || wdata !== t_exp[i]) begin fails++; $display("FAIL ext_wdata[%0d]: cb_we=%b rf_we=%b wdata=%h want 1 1 %h", i, cb_we, rf_we, wdata, t_exp[i]); end
            step();
            mem_rvalid = 0;
        end
    endtask

    task automatic test_store;
        logic [11:0] t_op   [4] = '{OP_SH, OP_SB, OP_SW, OP_SB};
        logic [31:0] t_imm  [4] = '{32'h2, 32'h1, 32'h8, 32'h3};
        logic [31:0] t_data [4] = '{32'h1234ABCD, 32'h000000EF, 32'hCAFEF00D, 32'h12345678};
        logic [3:0]  t_wen  [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
        logic [31:0] t_wd   [4] = '{32'hABCDABCD, 32'hEFEFEFEF, 32'hCAFEF00D, 32'h78787878};
        for (int i = 0; i < 4; i++) begin
            drive_issue(t_op[i], t_imm[i], 1'b1, 32'h100, t_data[i]);
            step();
            issue_valid = 0; mem_gnt = 1;
            #1;
            tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 + t_imm[i]) begin fails++; $display("FAIL st_req[%0d]: req=%b addr=%h want 1 %h", i, mem_req, mem_addr, 32'h100 + t_imm[i]); end
            tests++; if (mem_wen !== t_wen[i] || mem_wdata !== t_wd[i]) begin fails++; $display("FAIL st_bus[%0d]: wen=%b wdata=%h want %b %h", i, mem_wen, mem_wdata, t_wen[i], t_wd[i]); end
            step();
            mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h55555555;
            #1;
            tests++; if (cb_we !== 1'b1 || rf_we !== 1'b0 || wdata !== 32'h0) begin fails++; $display("FAIL st_wb[%0d]: cb_we=%b rf_we=%b wdata=%h want 1 0 0", i, cb_we, rf_we, wdata); end
            step();
            mem_rvalid = 0;
        end
    endtask

    task automatic test_misaligned;
        logic [11:0] t_op  [2] = '{OP_LW, OP_SH};
        logic [31:0] t_imm [2] = '{32'h2, 32'h3};
        for (int i = 0; i < 2; i++) begin
            drive_issue(t_op[i], t_imm[i], 1'b1, 32'h100, 32'hA5A5A5A5);
            step();
            issue_valid = 0; mem_gnt = 1;
            #1;
            tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL mis_req[%0d]: got %b want 0", i, mem_req); end
            tests++; if (cb_we !== 1'b0) begin fails++; $display("FAIL mis_early[%0d]: cb_we=%b want 0", i, cb_we); end
            step();
            mem_gnt = 0;
            #1;
            tests++; if (cb_we !== 1'b1 || excp !== 1'b1 || rf_we !== 1'b0) begin fails++; $display("FAIL mis_wb[%0d]: cb_we=%b excp=%b rf_we=%b want 1 1 0", i, cb_we, excp, rf_we); end
            tests++; if (excp_badvaddr !== 32'h100 + t_imm[i] || wdata !== 32'h0) begin fails++; $display("FAIL mis_addr[%0d]: badvaddr=%h wdata=%h want %h 0", i, excp_badvaddr, wdata, 32'h100 + t_imm[i]); end
            tests++; if (wb_status !== mk_st(t_imm[i], 1'b1)) begin fails++; $display("FAIL mis_status[%0d]: got %h want %h", i, wb_status, mk_st(t_imm[i], 1'b1)); end
            step();
            #1;
            tests++; if (cb_we !== 1'b0 || excp !== 1'b0) begin fails++; $display("FAIL mis_after[%0d]: cb_we=%b excp=%b want 0 0", i, cb_we, excp); end
        end
    endtask

    task automatic test_back_to_back;
        drive_issue(OP_LW, 32'h0, 1'b1, 32'h400, 32'h0);
        step();
        drive_issue(OP_LW, 32'h0, 1'b1, 32'h404, 32'h0); mem_gnt = 1;
        #1;
        tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h400 || issue_ready !== 1'b1) begin fails++; $display("FAIL b2b_req1: req=%b addr=%h rdy=%b want 1 400 1", mem_req, mem_addr, issue_ready); end
        step();
        drive_issue(OP_LW, 32'h0, 1'b1, 32'h408, 32'h0);
        #1;
        tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h404 || issue_ready !== 1'b1) begin fails++; $display("FAIL b2b_req2: req=%b addr=%h rdy=%b want 1 404 1", mem_req, mem_addr, issue_ready); end
        step();
        issue_valid = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            tests++; if (mem_req !== 1'b0 || issue_ready !== 1'b0 || cb_we !== 1'b0) begin fails++; $display("FAIL b2b_full[%0d]: req=%b rdy=%b cb_we=%b want 0 0 0", c, mem_req, issue_ready, cb_we); end
            step();
        end
        mem_rvalid = 1; mem_rdata = 32'h0000_1111;
        #1;
        tests++; if (cb_we !== 1'b1 || wdata !== 32'h0000_1111 || mem_req !== 1'b0) begin fails++; $display("FAIL b2b_wb1: cb_we=%b wdata=%h req=%b want 1 00001111 0", cb_we, wdata, mem_req); end
        step();
        mem_rdata = 32'h0000_2222;
        #1;
        tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h408) begin fails++; $display("FAIL b2b_req3: req=%b addr=%h want 1 408", mem_req, mem_addr); end
        tests++; if (cb_we !== 1'b1 || wdata !== 32'h0000_2222) begin fails++; $display("FAIL b2b_wb2: cb_we=%b wdata=%h want 1 00002222", cb_we, wdata); end
        step();
        mem_gnt = 0; mem_rdata = 32'h0000_3333;
        #1;
        tests++; if (cb_we !== 1'b1 || wdata !== 32'h0000_3333) begin fails++; $display("FAIL b2b_wb3: cb_we=%b wdata=%h want 1 00003333", cb_we, wdata); end
        step();
        mem_rvalid = 0;
        #1;
        tests++; if (cb_we !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL b2b_idle: cb_we=%b req=%b want 0 0", cb_we, mem_req); end
    endtask

    task automatic test_flush;
        // EX instruction killed before grant
        drive_issue(OP_LW, 32'h0, 1'b1, 32'h700, 32'h0);
        step();
        issue_valid = 0; mem_gnt = 1; flush = 1;
        #1;
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL fl_ex_req: got %b want 0", mem_req); end
        step();
        flush = 0; mem_gnt = 0;
        #1;
        tests++; if (mem_req !== 1'b0 || issue_ready !== 1'b1) begin fails++; $display("FAIL fl_ex_gone: req=%b rdy=%b want 0 1", mem_req, issue_ready); end
        step();
        // Two granted loads killed in the tracker
        drive_issue(OP_LW, 32'h0, 1'b1, 32'h500, 32'h0);
        step();
        drive_issue(OP_LW, 32'h0, 1'b1, 32'h504, 32'h0); mem_gnt = 1;
        step();
        issue_valid = 0;
        #1;
        tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h504) begin fails++; $display("FAIL fl_req2: req=%b addr=%h want 1 504", mem_req, mem_addr); end
        step();
        mem_gnt = 0; flush = 1;
        #1;
        tests++; if (cb_we !== 1'b0) begin fails++; $display("FAIL fl_cycle: cb_we=%b want 0", cb_we); end
        step();
        flush = 0; mem_rvalid = 1; mem_rdata = 32'h11111111;
        for (int c = 0; c < 2; c++) begin
            #1;
            tests++; if (cb_we !== 1'b0 || rf_we !== 1'b0 || excp !== 1'b0) begin fails++; $display("FAIL fl_drain[%0d]: cb_we=%b rf_we=%b excp=%b want 0 0 0", c, cb_we, rf_we, excp); end
            step();
            mem_rdata = 32'h22222222;
        end
        mem_rvalid = 0;
        // Next load completes normally
        drive_issue(OP_LW, 32'h0, 1'b1, 32'h600, 32'h0);
        step();
        issue_valid = 0; mem_gnt = 1;
        #1;
        tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h600) begin fails++; $display("FAIL fl_next_req: req=%b addr=%h want 1 600", mem_req, mem_addr); end
        step();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h33333333;
        #1;
        tests++; if (cb_we !== 1'b1 || rf_we !== 1'b1 || wdata !== 32'h33333333) begin fails++; $display("FAIL fl_next_wb: cb_we=%b rf_we=%b wdata=%h want 1 1 33333333", cb_we, rf_we, wdata); end
        step();
        mem_rvalid = 0;
        // Flush in the same cycle as a completion kills it
        drive_issue(OP_LW, 32'h0, 1'b1, 32'h604, 32'h0);
        step();
        issue_valid = 0; mem_gnt = 1;
        step();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h44444444; flush = 1;
        #1;
        tests++; if (cb_we !== 1'b0 || rf_we !== 1'b0) begin fails++; $display("FAIL fl_same_cycle: cb_we=%b rf_we=%b want 0 0", cb_we, rf_we); end
        step();
        mem_rvalid = 0; flush = 0;
        drive_issue(OP_LW, 32'h0, 1'b1, 32'h608, 32'h0);
        step();
        issue_valid = 0; mem_gnt = 1;
        step();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h55556666;
        #1;
        tests++; if (cb_we !== 1'b1 || wdata !== 32'h55556666) begin fails++; $display("FAIL fl_after_same: cb_we=%b wdata=%h want 1 55556666", cb_we, wdata); end
        step();
        mem_rvalid = 0;
    endtask

    task automatic test_reset_mid;
        drive_issue(OP_LW, 32'h0, 1'b1, 32'h800, 32'h0);
        step();
        drive_issue(OP_LW, 32'h0, 1'b1, 32'h804, 32'h0); mem_gnt = 1;
        step();
        issue_valid = 0; mem_gnt = 0; rst = 1;
        #1;
        tests++; if (mem_req !== 1'b0 || issue_ready !== 1'b1 || cb_we !== 1'b0) begin fails++; $display("FAIL rst_mid: req=%b rdy=%b cb_we=%b want 0 1 0", mem_req, issue_ready, cb_we); end
        step();
        rst = 0;
        drive_issue(OP_LW, 32'h10, 1'b1, 32'h8F0, 32'h0);
        step();
        issue_valid = 0; mem_gnt = 1;
        step();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h99999999;
        #1;
        tests++; if (cb_we !== 1'b1 || wdata !== 32'h99999999 || wb_status !== mk_st(32'h10, 1'b1)) begin fails++; $display("FAIL rst_mid_wb: cb_we=%b wdata=%h status=%h want 1 99999999 %h", cb_we, wdata, wb_status, mk_st(32'h10, 1'b1)); end
        step();
        mem_rvalid = 0;
        #1;
        tests++; if (cb_we !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL rst_mid_idle: cb_we=%b req=%b want 0 0", cb_we, mem_req); end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_misaligned();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
